// File: rtl/sample_tx_pkg.sv
// Shared types and framing constants for the sample UART transmitter.
package sample_tx_pkg;

  // Byte-level serialiser states.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Upper six bits of the first character; marks the frame start on the line.
  localparam logic [5:0]  FRAME_MARKER  = 6'b101000;
  localparam int unsigned FRAME_BYTES   = 2;
  // Start + 8 data + stop.
  localparam int unsigned BITS_PER_CHAR = 10;

  // Character idx (0 or 1) of the two-character frame for a 10-bit sample.
  function automatic logic [7:0] frame_byte(input logic [9:0] sample, input logic idx);
    frame_byte = idx ? sample[7:0] : {FRAME_MARKER, sample[9:8]};
  endfunction

endpackage

// File: rtl/sample_uart_tx_if.sv
// Strobed sample stream from the filter: data is valid only while strobe is high.
interface sample_uart_tx_if #(
  parameter int unsigned DATA_W = 10
) ();

  logic              strobe;
  logic [DATA_W-1:0] data;

  modport master (output strobe, output data);
  modport slave  (input  strobe, input  data);

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A new byte is taken when i_start is high while o_ready is high;
// o_ready is also high in the last cycle of the stop bit so bytes can run back-to-back.
module uart_byte_tx
  import sample_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_start,
  input  logic [7:0] i_byte,
  output logic      o_ready,
  output logic      o_tx,
  output tx_state_e o_state
);

  localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam int unsigned     DataBits = BITS_PER_CHAR - 2;
  localparam logic [2:0]      LastBit  = 3'(DataBits - 1);

  tx_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            w_bit_end;

  // Baud tick and load window, decoded from registered state.
  always_comb begin
    w_bit_end = (r_cnt == CntMax);
    o_ready   = (r_state == StIdle) || ((r_state == StStop) && w_bit_end);
  end

  assign o_tx    = r_tx;
  assign o_state = r_state;

  // Bit sequencing; tx is registered so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StStart;
            r_shift <= i_byte;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == LastBit) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (i_start) begin
              r_state <= StStart;
              r_shift <= i_byte;
              r_bit   <= '0;
              r_tx    <= 1'b0;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/sample_uart_tx.sv
// Serialises filter samples as two-character 8N1 frames. A one-deep hold register absorbs
// strobes while a frame is on the line; a strobe that finds it full is dropped and flagged.
module sample_uart_tx
  import sample_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  sample_uart_tx_if.slave  s_if,
  input  logic             ovr_clr_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned IdxW = $clog2(FRAME_BYTES);

  logic [DATA_W-1:0] r_hold;
  logic              r_hold_valid;
  logic [7:0]        r_lo_byte;
  logic [IdxW-1:0]   r_byte_idx;
  logic              r_overrun;

  tx_state_e  w_state;
  logic       w_ready;
  logic       w_start;
  logic [7:0] w_byte;
  logic       w_next_lo;
  logic       w_consume;
  logic       w_accept;
  logic       w_drop;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_byte  (w_byte),
    .o_ready (w_ready),
    .o_tx    (tx_o),
    .o_state (w_state)
  );

  // Byte selection and hold-register arbitration.
  always_comb begin
    // Second character of the current frame always follows the first.
    w_next_lo = (w_state == StStop) && (r_byte_idx == '0);
    w_start   = w_next_lo ? 1'b1 : r_hold_valid;
    w_byte    = w_next_lo ? r_lo_byte : frame_byte(r_hold, 1'b0);
    w_consume = w_ready && !w_next_lo && r_hold_valid;
    // A strobe coinciding with consumption refills the hold register.
    w_accept  = s_if.strobe && (!r_hold_valid || w_consume);
    w_drop    = s_if.strobe && r_hold_valid && !w_consume;
  end

  // Hold register, frame sequencing and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_lo_byte    <= '0;
      r_byte_idx   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold       <= s_if.data;
        r_hold_valid <= 1'b1;
      end else if (w_consume) begin
        r_hold_valid <= 1'b0;
      end
      if (w_ready && w_start) begin
        r_byte_idx <= w_next_lo ? IdxW'(1) : '0;
      end
      // Second character is snapshotted so a later hold rewrite cannot touch this frame.
      if (w_consume) begin
        r_lo_byte <= frame_byte(r_hold, 1'b1);
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign busy_o    = (w_state != StIdle) | r_hold_valid;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx at 4 clocks per bit; a line monitor decodes 8N1 characters.
module tb_sample_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       start_ok;
    logic       stop;
  } rx_t;

  logic clk = 1'b0;
  logic reset;
  logic ovr_clr;
  logic tx;
  logic busy;
  logic overrun;
  int   cyc = 0;
  int   rst_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k;
  rx_t  rx_q[$];

  rx_t        mon_e;
  int         mon_r0;
  logic [7:0] mon_b;
  logic       mon_st;

  sample_uart_tx_if #(.DATA_W(10)) s_if ();

  sample_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_if      (s_if),
    .ovr_clr_i (ovr_clr),
    .tx_o      (tx),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge reset);
    rst_cnt++;
  end

  // Line monitor: detect start on a low sample, then sample mid-bit.
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0 && reset === 1'b0) begin
      mon_r0      = rst_cnt;
      mon_e.start = cyc;
      repeat (CPB / 2) @(negedge clk);
      mon_st = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      mon_e.stop     = tx;
      mon_e.data     = mon_b;
      mon_e.start_ok = mon_st;
      if (rst_cnt == mon_r0) rx_q.push_back(mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Strobe so that the DUT samples it at posedge number edge_n; returns at the following negedge.
  task automatic send_sample(input int edge_n, input logic [9:0] d, input logic clr);
    wait_cyc(edge_n - 1);
    s_if.strobe = 1'b1;
    s_if.data   = d;
    ovr_clr     = clr;
    @(negedge clk);
    s_if.strobe = 1'b0;
    ovr_clr     = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input int t0);
    rx_t e0;
    rx_t e1;
    check_eq({tag, "_avail"}, 32'(rx_q.size() >= 2), 32'd1);
    if (rx_q.size() >= 2) begin
      e0 = rx_q.pop_front();
      e1 = rx_q.pop_front();
      check_eq({tag, "_b0"}, 32'(e0.data), 32'(b0));
      check_eq({tag, "_b1"}, 32'(e1.data), 32'(b1));
      check_eq({tag, "_t0"}, 32'(e0.start), 32'(t0));
      check_eq({tag, "_t1"}, 32'(e1.start), 32'(t0 + 10 * CPB));
      check_eq({tag, "_framing"}, {28'd0, e0.start_ok, e0.stop, e1.start_ok, e1.stop}, 32'hF);
    end
  endtask

  initial begin
    reset       = 1'b1;
    ovr_clr     = 1'b0;
    s_if.strobe = 1'b0;
    s_if.data   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_tx", 32'(tx), 32'd1);

    // 1: single sample, latency, decode, frame length.
    k = cyc + 2;
    send_sample(k, 10'h3A5, 1'b0);
    check_eq("t1_tx_at_strobe", 32'(tx), 32'd1);
    check_eq("t1_busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t1_start_bit", 32'(tx), 32'd0);
    wait_cyc(k + 80);
    check_eq("t1_busy_last_stop", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t1_busy_fall", 32'(busy), 32'd0);
    check_eq("t1_tx_idle", 32'(tx), 32'd1);
    check_frame("t1", 8'hA3, 8'hA5, k + 1);

    // 2: second sample held, frames back-to-back.
    k = cyc + 2;
    send_sample(k, 10'h001, 1'b0);
    send_sample(k + 10, 10'h2FF, 1'b0);
    wait_cyc(k + 161);
    check_eq("t2_busy", 32'(busy), 32'd0);
    check_eq("t2_ovr", 32'(overrun), 32'd0);
    check_frame("t2a", 8'hA0, 8'h01, k + 1);
    check_frame("t2b", 8'hA2, 8'hFF, k + 81);

    // 3: third sample while hold full is dropped; overrun sticky until cleared.
    k = cyc + 2;
    send_sample(k, 10'h0AB, 1'b0);
    send_sample(k + 10, 10'h123, 1'b0);
    check_eq("t3_ovr_before", 32'(overrun), 32'd0);
    send_sample(k + 20, 10'h3FF, 1'b0);
    check_eq("t3_ovr_set", 32'(overrun), 32'd1);
    wait_cyc(k + 161);
    check_eq("t3_ovr_sticky", 32'(overrun), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_frame("t3a", 8'hA0, 8'hAB, k + 1);
    check_frame("t3b", 8'hA1, 8'h23, k + 81);
    check_eq("t3_no_extra", 32'(rx_q.size()), 32'd0);
    pulse_clr();
    check_eq("t3_ovr_clr", 32'(overrun), 32'd0);

    // 4: strobe exactly when the held sample is consumed.
    k = cyc + 2;
    send_sample(k, 10'h2C3, 1'b0);
    send_sample(k + 10, 10'h04E, 1'b0);
    send_sample(k + 81, 10'h1B7, 1'b0);
    check_eq("t4_ovr", 32'(overrun), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd1);
    wait_cyc(k + 241);
    check_eq("t4_busy_end", 32'(busy), 32'd0);
    check_eq("t4_ovr_end", 32'(overrun), 32'd0);
    check_frame("t4a", 8'hA2, 8'hC3, k + 1);
    check_frame("t4b", 8'hA0, 8'h4E, k + 81);
    check_frame("t4c", 8'hA1, 8'hB7, k + 161);

    // 5: reset during data bits of the first character.
    k = cyc + 2;
    send_sample(k, 10'h0F0, 1'b0);
    wait_cyc(k + 12);
    check_eq("t5_tx_pre", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("t5_tx_rst", 32'(tx), 32'd1);
    check_eq("t5_busy_rst", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send_sample(k + 70, 10'h155, 1'b0);
    wait_cyc(k + 151);
    check_frame("t5", 8'hA1, 8'h55, k + 71);
    check_eq("t5_no_extra", 32'(rx_q.size()), 32'd0);

    // 6: clear coinciding with a new overrun; the overrun wins.
    k = cyc + 2;
    send_sample(k, 10'h3C0, 1'b0);
    send_sample(k + 5, 10'h00F, 1'b0);
    send_sample(k + 8, 10'h3FF, 1'b1);
    check_eq("t6_set_with_clr", 32'(overrun), 32'd1);
    send_sample(k + 12, 10'h3AA, 1'b1);
    check_eq("t6_keep_with_clr", 32'(overrun), 32'd1);
    pulse_clr();
    check_eq("t6_clr", 32'(overrun), 32'd0);
    wait_cyc(k + 161);
    check_frame("t6a", 8'hA3, 8'hC0, k + 1);
    check_frame("t6b", 8'hA0, 8'h0F, k + 81);
    check_eq("t6_no_extra", 32'(rx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
Consumes the strobed 10-bit sample stream produced by the moving-average filter (data + one-cycle strobe) and serialises each sample as a two-character 8N1 UART frame on a single pin. A one-deep holding register decouples the filter's strobe timing from the slow serial line. Overruns are flagged rather than stalling the filter, because that interface has no backpressure. Sits between the filter output and a uio output pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2.
DATA_W, 10, sample width; fixed at 10 for the framing below.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
strobe_i  input  1  one-cycle pulse; data_i valid this cycle
data_i  input  10  sample value
ovr_clr_i  input  1  synchronous clear of overrun_o
tx_o  output  1  UART line, idle high
busy_o  output  1  high while a frame is in flight or the holding register is full
overrun_o  output  1  sticky; a sample was dropped

Behaviour:
- Reset values: tx_o=1, busy_o=0, overrun_o=0, hold_valid=0, state IDLE. All counters are 0. Asserting reset mid-frame forces tx_o=1 immediately. Any partial frame is abandoned.
- Frame: byte0 = {6'b101000, data[9:8]} (0xA0 | MSBs), then byte1 = data[7:0].
  - Each byte is start(0), 8 data bits LSB first, stop(1).
  - Each bit lasts CLKS_PER_BIT cycles.
  - byte1 follows byte0's stop bit with no gap.
  - Frame length = 20*CLKS_PER_BIT cycles.
- Capture: strobe_i high at edge k loads the hold register and sets hold_valid.
- Latency: if IDLE at edge k, the FSM consumes hold at edge k+1 and tx_o=0 (start bit) from edge k+1. tx_o is registered (no glitches).
- FSM states: IDLE, START, DATA, STOP; byte_idx selects 0/1.
  - IDLE -> START when hold_valid: load shift register with byte0, clear hold_valid, byte_idx=0.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP when byte_idx=0 -> START with byte1, byte_idx=1.
  - STOP when byte_idx=1 -> START with the next byte0 if hold_valid (back-to-back, no idle cycle); otherwise IDLE.
- Hold/overrun rules:
  - Strobe in the same cycle the FSM consumes hold: the new sample is accepted, hold_valid stays 1, no overrun.
  - Strobe while hold_valid=1 and not being consumed: the sample is dropped, hold is unchanged, overrun_o=1 next cycle.
  - ovr_clr_i clears overrun_o. A simultaneous new overrun wins (overrun_o stays 1).
- The sample latched at frame start is immutable for the frame (copied into the shift register). hold may be rewritten only per the rules above.
- busy_o = (state != IDLE) | hold_valid, combinational from registers.
- Baud counter width is $clog2(CLKS_PER_BIT). Wrap happens at CLKS_PER_BIT-1, not a power of two.

Decomposition:
- Package sample_tx_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the marker constant 6'b101000;
  - FRAME_BYTES=2 and BITS_PER_CHAR=10.
- Sub-module uart_byte_tx handles the byte level: start/ready handshake, baud counter, shift register, tx_o register.
- The top module handles hold register, overrun, byte sequencing and busy.

Test Plan:
1. Reset, then strobe data_i=10'h3A5 (CLKS_PER_BIT=4) -> tx_o low at the cycle after the strobe edge. Line decodes 0xA3 then 0xA5, frame is 80 cycles, busy_o falls the cycle after the final stop bit.
2. Strobe 10'h001, then strobe 10'h2FF 10 cycles later -> second sample held. Frames 0xA0,0x01 then 0xA2,0xFF back-to-back with no idle cycle, overrun_o=0.
3. Strobe A, strobe B while B's frame would still be held, then strobe C while hold is full -> C dropped, overrun_o=1 sticky. Only A and B appear on the line. ovr_clr_i pulse -> overrun_o=0.
4. Strobe in the exact cycle the FSM consumes hold -> new value accepted, no overrun, transmitted next.
5. Assert reset during byte0's data bits -> tx_o=1 at once, busy_o=0. The next strobe (10'h155) produces a clean frame 0xA1,0x55.
6. Strobe with ovr_clr_i and an overrun condition in the same cycle -> overrun_o remains 1.
